note_gen: RTL and testbench

Audio tone generator sitting downstream of the beat player and its note lookup. It consumes per-channel half-period divisors, one for each of the left and right channels, plus a shared volume. It produces two signed square-wave sample streams for the speaker serializer. Volume changes are deferred to wave edges so they do not click. With the gap option built in, a short silence separates consecutive notes.

---
 rtl/note_gen.sv | 80 ++++++++
 tb/tb_note_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/note_gen.sv
// note_gen: dual-channel square-wave tone generator with volume changes deferred to wave edges.
// Define NOTE_GAP_EN to silence each channel for GAP_CYCLES cycles after every note change.
module note_gen #(
  parameter int          DIV_WIDTH  = 22,
  parameter logic [15:0] GAP_CYCLES = 16'd4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] note_div_left,
  input  logic [DIV_WIDTH-1:0] note_div_right,
  input  logic [2:0]           volume,
  input  logic                 mute,
  output logic [15:0]          audio_left,
  output logic [15:0]          audio_right
);
  logic mute_q;
`ifndef NOTE_GAP_EN
  logic unused_gap;
  assign unused_gap = ^GAP_CYCLES;
`endif
  // mute is registered so it takes effect with the same one-cycle lag as a note change
  always_ff @(posedge clk or negedge reset)
    if (!reset) mute_q <= 1'b0;
    else mute_q <= mute;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_in, div_q, cnt;
    logic                 phase, change, tone, wrap, silent, gap_busy;
    logic [2:0]           vol_q;
    logic [15:0]          amp, audio_q;
    assign div_in = (c == 0) ? note_div_left : note_div_right;
`ifdef NOTE_GAP_EN
    logic [15:0] gap_cnt;
    always_ff @(posedge clk or negedge reset)
      if (!reset) gap_cnt <= '0;
      else if (change) gap_cnt <= GAP_CYCLES;
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
    assign gap_busy = gap_cnt != '0;
`else
    assign gap_busy = 1'b0;
`endif
    always_comb begin
      change = div_in != div_q;
      tone   = div_q >= DIV_WIDTH'(2);
      wrap   = tone && cnt == div_q - DIV_WIDTH'(1);
      silent = !tone || mute_q || gap_busy || vol_q == 3'd0;
      amp    = vol_q == 3'd1 ? 16'h0400 :
               vol_q == 3'd2 ? 16'h0800 :
               vol_q == 3'd3 ? 16'h1000 :
               vol_q == 3'd4 ? 16'h2000 : 16'h3FFF;
    end
    // a note change overrides any toggle due on the same edge
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        div_q   <= '0;
        cnt     <= '0;
        phase   <= 1'b1;
        vol_q   <= 3'd0;
        audio_q <= 16'h0000;
      end else begin
        if (wrap || silent) vol_q <= volume;
        audio_q <= silent ? 16'h0000 : phase ? amp : -amp;
        if (change) begin
          div_q <= div_in;
          cnt   <= '0;
          phase <= 1'b1;
        end else if (!tone) begin
          cnt   <= '0;
          phase <= 1'b1;
        end else if (wrap) begin
          cnt   <= '0;
          phase <= ~phase;
        end else cnt <= cnt + DIV_WIDTH'(1);
      end
    if (c == 0) begin : g_l
      assign audio_left = audio_q;
    end else begin : g_r
      assign audio_right = audio_q;
    end
  end
endmodule

// File: tb/tb_note_gen.sv
// tb_note_gen: directed checks of reset, tone, rest, volume deferral, mute and (with NOTE_GAP_EN) the note gap.
module tb_note_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mute = 1'b0;
  logic [21:0] dl = '0, dr = '0;
  logic [2:0]  volume = 3'd5;
  logic [15:0] al, ar;
  int checks = 0, fails = 0;

  note_gen #(.DIV_WIDTH(22), .GAP_CYCLES(16'd16)) dut (
    .clk(clk), .reset(reset), .note_div_left(dl), .note_div_right(dr),
    .volume(volume), .mute(mute), .audio_left(al), .audio_right(ar)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] sq(input int k, input int d);
    return (k % (2 * d)) < d ? 16'h3FFF : 16'hC001;
  endfunction

  task automatic start_note(input logic [21:0] l, input logic [21:0] r);
    dl = '0; dr = '0;
    step(); step();
    dl = l; dr = r;
    step();
    checks++;
    if (al !== 16'h0000) begin fails++; $display("FAIL start_note: audio_left=%h expected 0000", al); end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    dl = 22'd4; volume = 3'd5;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (al !== 16'h0000 || ar !== 16'h0000) begin
        fails++; $display("FAIL reset_hold: left=%h right=%h expected 0000", al, ar);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (al !== 16'h0000) begin fails++; $display("FAIL reset_first: audio_left=%h expected 0000", al); end
`ifndef NOTE_GAP_EN
    step();
    checks++;
    if (al !== 16'h3FFF) begin fails++; $display("FAIL reset_second: audio_left=%h expected 3fff", al); end
    checks++;
    if (ar !== 16'h0000) begin fails++; $display("FAIL reset_right: audio_right=%h expected 0000", ar); end
`endif
  endtask

  task automatic test_tone();
    start_note(22'd4, 22'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if (al !== sq(k, 4)) begin fails++; $display("FAIL tone k=%0d: audio_left=%h expected %h", k, al, sq(k, 4)); end
      checks++;
      if (ar !== 16'h0000) begin fails++; $display("FAIL tone_right k=%0d: audio_right=%h expected 0000", k, ar); end
    end
  endtask

  task automatic test_rest();
    start_note(22'd4, 22'd0);
    step(); step();
    dl = 22'd1;
    step();
    checks++;
    if (al !== 16'h3FFF) begin fails++; $display("FAIL rest_edge: audio_left=%h expected 3fff", al); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (al !== 16'h0000) begin fails++; $display("FAIL rest_hold i=%0d: audio_left=%h expected 0000", i, al); end
    end
    dl = 22'd4;
    step();
    checks++;
    if (al !== 16'h0000) begin fails++; $display("FAIL rest_restore0: audio_left=%h expected 0000", al); end
    step();
    checks++;
    if (al !== 16'h3FFF) begin fails++; $display("FAIL rest_restore1: audio_left=%h expected 3fff", al); end
  endtask

  task automatic test_volume();
    logic [15:0] exp;
    start_note(22'd8, 22'd0);
    for (int k = 0; k < 17; k++) begin
      if (k == 3) volume = 3'd1;
      step();
      exp = k < 8 ? 16'h3FFF : k < 16 ? 16'hFC00 : 16'h0400;
      checks++;
      if (al !== exp) begin fails++; $display("FAIL volume k=%0d: audio_left=%h expected %h", k, al, exp); end
    end
    volume = 3'd5;
  endtask

  task automatic test_mute();
    logic [15:0] exp;
    start_note(22'd4, 22'd4);
    for (int k = 0; k < 16; k++) begin
      if (k == 2) mute = 1'b1;
      if (k == 7) mute = 1'b0;
      step();
      exp = (k >= 3 && k <= 7) ? 16'h0000 : sq(k, 4);
      checks++;
      if (al !== exp) begin fails++; $display("FAIL mute_left k=%0d: audio_left=%h expected %h", k, al, exp); end
      checks++;
      if (ar !== exp) begin fails++; $display("FAIL mute_right k=%0d: audio_right=%h expected %h", k, ar, exp); end
    end
  endtask

`ifdef NOTE_GAP_EN
  task automatic test_gap();
    logic [15:0] exp;
    dl = '0; dr = '0;
    step(); step();
    dl = 22'd6;
    for (int i = 0; i < 20; i++) step();
    dl = 22'd10;
    step();
    for (int k = 0; k < 36; k++) begin
      step();
      exp = k < 16 ? 16'h0000 : sq(k, 10);
      checks++;
      if (al !== exp) begin fails++; $display("FAIL gap k=%0d: audio_left=%h expected %h", k, al, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef NOTE_GAP_EN
    test_gap();
`else
    test_tone();
    test_rest();
    test_volume();
    test_mute();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
